niosqs_pio_gen2: RTL and testbench

// - Parametrised Avalon-MM general-purpose I/O port; successor to the fixed 8-bit output-only PIO.
// - Per-bit direction, input synchronisation, edge capture, maskable level IRQ, and atomic set/clear of outputs.
// - Sits on the Nios II data master as an Avalon slave with zero-wait-state reads; drives LCD/LED pins and samples switches/keys.

---
 rtl/niosqs_pio_gen2.sv | 127 ++++++++++++
 tb/tb_niosqs_pio_gen2.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/niosqs_pio_gen2.sv
// Avalon-MM general-purpose I/O port: per-bit direction, synchronised inputs,
// edge capture with write-1-to-clear, maskable level IRQ and atomic output set/clear.
module niosqs_pio_gen2 #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'hFF,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0]       PRIME_MAX  = 3'(SYNC_STAGES + 1);
  localparam logic [WIDTH-1:0] DATA_INIT  = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DIR_INIT   = DIR_RESET[WIDTH-1:0];

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] prev_p;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic [2:0]       prime_cnt;
  logic             primed;
  logic             wr;
  logic             unused_wd;

  function automatic logic [WIDTH-1:0] edge_select(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prv);
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    rise = cur & ~prv;
    fall = ~cur & prv;
    case (EDGE_TYPE)
      0:       return rise;
      1:       return fall;
      default: return rise | fall;
    endcase
  endfunction

  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;
  assign in_sync   = sync_p[SYNC_STAGES-1];
  assign primed    = (prime_cnt == PRIME_MAX);
  assign edge_det  = primed ? edge_select(in_sync, prev_p) : '0;

  // Input synchroniser and previous-sample stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_p <= in_sync;
    end
  end

  // Priming holds off edge capture until the synchroniser has filled from reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        prime_cnt <= '0;
    else if (!primed) prime_cnt <= prime_cnt + 3'd1;
  end

  // Register file; a new edge wins over a simultaneous write-1-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out     <= DATA_INIT;
      dir          <= DIR_INIT;
      mask         <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_DATA:   data_out <= wd;
          ADDR_DIR:    dir      <= wd;
          ADDR_MASK:   mask     <= wd;
          ADDR_OUTSET: data_out <= data_out | wd;
          ADDR_OUTCLR: data_out <= data_out & ~wd;
          default:     ;
        endcase
      end
      if (wr && address == ADDR_EDGE) edge_capture <= (edge_capture & ~wd) | edge_det;
      else                            edge_capture <= edge_capture | edge_det;
      irq <= |(edge_capture & mask);
    end
  end

  always_comb begin
    rd = '0;
    case (address)
      ADDR_DATA: rd = (dir & data_out) | (~dir & in_sync);
      ADDR_DIR:  rd = dir;
      ADDR_MASK: rd = mask;
      ADDR_EDGE: rd = edge_capture;
      default:   rd = '0;
    endcase
    readdata = 32'(rd);
  end

  assign out_port = data_out;
  assign oe       = dir;

endmodule

// File: tb/tb_niosqs_pio_gen2.sv
// Directed bench for niosqs_pio_gen2 at default parameters (WIDTH=8, rising edge, 2 sync stages).
module tb_niosqs_pio_gen2;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int total = 0;
  int bad   = 0;

  niosqs_pio_gen2 dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write spans one rising edge; returns at the following falling edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'hFF;

    // Reset values, with pins high through reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_port", {24'h0, out_port}, 32'h00);
    chk("rst_oe", {24'h0, oe}, 32'hFF);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd_chk("rst_rd_dir", 3'd1, 32'hFF);
    rd_chk("rst_rd_mask", 3'd2, 32'h0);
    rd_chk("rst_rd_edge", 3'd3, 32'h0);
    rd_chk("rst_rd_outset", 3'd4, 32'h0);
    rd_chk("rst_rd_outclr", 3'd5, 32'h0);

    // Priming: no spurious edge from pins high at reset exit
    wr(3'd2, 32'hFF);
    repeat (6) @(negedge clk);
    rd_chk("prime_edge", 3'd3, 32'h0);
    chk("prime_irq", {31'h0, irq}, 32'h0);
    wr(3'd2, 32'h00);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    rd_chk("prime_edge_after_fall", 3'd3, 32'h0);

    // Output set/clear
    wr(3'd0, 32'h0F);
    chk("data_wr", {24'h0, out_port}, 32'h0F);
    wr(3'd4, 32'hA0);
    chk("outset", {24'h0, out_port}, 32'hAF);
    wr(3'd5, 32'h03);
    chk("outclr", {24'h0, out_port}, 32'hAC);
    rd_chk("rd_data_out", 3'd0, 32'hAC);
    wr(3'd6, 32'hFF);
    chk("addr6_ignored", {24'h0, out_port}, 32'hAC);
    rd_chk("rd_addr7", 3'd7, 32'h0);

    // Input read through direction mux
    wr(3'd1, 32'hF0);
    chk("dir_oe", {24'h0, oe}, 32'hF0);
    chk("dir_keeps_data", {24'h0, out_port}, 32'hAC);
    in_port = 8'h5A;
    repeat (3) @(negedge clk);
    rd_chk("rd_data_mixed", 3'd0, 32'hAA);
    rd_chk("edge_rising_bits", 3'd3, 32'h5A);
    chk("no_irq_masked", {31'h0, irq}, 32'h0);
    wr(3'd3, 32'hFF);
    rd_chk("edge_cleared", 3'd3, 32'h0);

    // Edge capture latency and IRQ on bit 0
    wr(3'd2, 32'h01);
    address = 3'd3; chipselect = 1'b1; write_n = 1'b1;
    in_port = 8'h5B;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lat_edge_k1", readdata, 32'h0);
    @(posedge clk); #1;
    chk("lat_edge_k2", readdata, 32'h01);
    chk("lat_irq_k2", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    chk("lat_irq_k3", {31'h0, irq}, 32'h1);
    wr(3'd3, 32'h01);
    rd_chk("edge0_cleared", 3'd3, 32'h0);
    chk("irq_still_high", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    chk("irq_dropped", {31'h0, irq}, 32'h0);

    // Edge on bit 2 lands on the same edge as its clear: set wins
    @(negedge clk);
    in_port = 8'h5F;
    @(negedge clk);
    @(negedge clk);
    address = 3'd3; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    rd_chk("collision_set_wins", 3'd3, 32'h04);
    wr(3'd3, 32'h04);
    rd_chk("collision_cleared", 3'd3, 32'h0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_port", {24'h0, out_port}, 32'h00);
    chk("midrst_oe", {24'h0, oe}, 32'hFF);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    rd_chk("midrst_prime_edge", 3'd3, 32'h0);
    rd_chk("midrst_data", 3'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
